// File: rtl/rom_fetch.sv
// ROM read initiator with a 2-entry prefetch buffer.
// Drives rom_a/en/ce from the PC and hands words downstream via valid/ready.
module rom_fetch #(
    parameter int A_BITS   = 8,
    parameter int D_WIDTH  = 8,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt,
    input  logic               jmp_valid,
    input  logic [A_BITS-1:0]  jmp_addr,
    output logic [A_BITS-1:0]  rom_a,
    input  logic [D_WIDTH-1:0] rom_d,
    output logic               rom_en,
    output logic               rom_ce,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_instr,
    output logic [A_BITS-1:0]  out_pc,
    output logic               running
);

    localparam logic [A_BITS-1:0] PC_RST = A_BITS'(RESET_PC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state;
    logic [A_BITS-1:0]  pc;
    logic [1:0]         cnt;

    // entry 0 is the head; it keeps its value when the buffer empties
    logic [D_WIDTH-1:0] e0_instr;
    logic [A_BITS-1:0]  e0_pc;
    logic [D_WIDTH-1:0] e1_instr;
    logic [A_BITS-1:0]  e1_pc;

    logic pop;
    logic fetch;

    // handshake and fetch qualification
    always_comb begin
        out_valid = (cnt != 2'd0);
        pop       = out_valid & out_ready;
        fetch     = (state == RUN) & ~halt & ~jmp_valid
                  & ((cnt != 2'd2) | pop);
    end

    assign rom_a     = pc;
    assign rom_en    = fetch;
    assign rom_ce    = (state == RUN);
    assign running   = (state == RUN);
    assign out_instr = e0_instr;
    assign out_pc    = e0_pc;

    // control FSM: halt wins over start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start && !halt) state <= RUN;
                RUN:     if (halt)           state <= HALTED;
                HALTED:  if (start && !halt) state <= RUN;
                default:                     state <= IDLE;
            endcase
        end
    end

    // program counter: jump redirects, fetch advances with wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= PC_RST;
        end else if (jmp_valid) begin
            pc <= jmp_addr;
        end else if (fetch) begin
            pc <= pc + 1'b1;
        end
    end

    // prefetch FIFO; a jump drops everything except a pop in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 2'd0;
            e0_instr <= '0;
            e0_pc    <= '0;
            e1_instr <= '0;
            e1_pc    <= '0;
        end else if (jmp_valid) begin
            cnt <= 2'd0;
        end else begin
            unique case ({fetch, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        e0_instr <= rom_d;
                        e0_pc    <= pc;
                    end else begin
                        e1_instr <= rom_d;
                        e1_pc    <= pc;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    if (cnt == 2'd2) begin
                        e0_instr <= e1_instr;
                        e0_pc    <= e1_pc;
                    end
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        e0_instr <= rom_d;
                        e0_pc    <= pc;
                    end else begin
                        e0_instr <= e1_instr;
                        e0_pc    <= e1_pc;
                        e1_instr <= rom_d;
                        e1_pc    <= pc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
